// File: rtl/max7219_receiver.sv
// Far-end receiver for the MAX7219 serial link: synchronises DIN/CS/SCLK,
// deserialises 16-bit frames and keeps a shadow copy of the display registers.
module max7219_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DIN,
  input  logic        CS,
  input  logic        SCLK,
  input  logic [2:0]  row_sel,
  output logic [7:0]  row_data,
  output logic        reg_wr_valid,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic        frame_err,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown,
  output logic        display_test,
  output logic [15:0] frame_count
);

  // [SYNC_STAGES-1] is the synchronised value, [SYNC_STAGES] the history flop
  logic [SYNC_STAGES:0] din_sr, cs_sr, sclk_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_sr  <= '0;
      cs_sr   <= '1;
      sclk_sr <= '0;
    end else begin
      din_sr  <= {din_sr[SYNC_STAGES-1:0], DIN};
      cs_sr   <= {cs_sr[SYNC_STAGES-1:0], CS};
      sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], SCLK};
    end
  end

  logic din_s, cs_s, cs_rise, cs_fall, sclk_rise;

  assign din_s     = din_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_sr[SYNC_STAGES];
  assign cs_fall   = ~cs_s & cs_sr[SYNC_STAGES];
  assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_sr[SYNC_STAGES] & ~cs_s;

  // Only the low 12 bits of a frame reach the decoder, so the top nibble is never stored
  logic [11:0] shift;
  logic [4:0]  bit_cnt;
  logic        accept, too_short, too_long;
  logic [3:0]  addr_m1;
  logic [7:0]  digit [8];

  assign accept    = cs_rise && (bit_cnt >= 5'd16);
  assign too_short = cs_rise && (bit_cnt < 5'd16);
  assign too_long  = cs_rise && (bit_cnt > 5'd16);
  assign addr_m1   = shift[11:8] - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (cs_rise) begin
      bit_cnt <= bit_cnt;
    end else if (cs_fall) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      shift <= {shift[10:0], din_s};
      if (bit_cnt != 5'd31)
        bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_valid <= 1'b0;
      frame_err    <= 1'b0;
      reg_addr     <= '0;
      reg_data     <= '0;
      frame_count  <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown     <= 1'b1;
      display_test <= 1'b0;
      for (int i = 0; i < 8; i++)
        digit[i] <= '0;
    end else begin
      reg_wr_valid <= accept;
      frame_err    <= too_short | too_long;
      if (accept) begin
        reg_addr    <= shift[11:8];
        reg_data    <= shift[7:0];
        frame_count <= frame_count + 16'd1;
        case (shift[11:8])
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit[addr_m1[2:0]] <= shift[7:0];
          4'h9:    decode_mode  <= shift[7:0];
          4'hA:    intensity    <= shift[3:0];
          4'hB:    scan_limit   <= shift[2:0];
          4'hC:    shutdown     <= ~shift[0];
          4'hF:    display_test <= shift[0];
          default: ;
        endcase
      end
    end
  end

  // Read sees the pre-write value when the same row is written on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      row_data <= '0;
    else
      row_data <= digit[row_sel];
  end

endmodule

// File: tb/tb_max7219_receiver.sv
// Scoreboard bench for max7219_receiver: directed frames push expected write/error
// events; a monitor pops and compares them whenever the DUT pulses.
module tb_max7219_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        DIN = 1'b0;
  logic        CS = 1'b1;
  logic        SCLK = 1'b0;
  logic [2:0]  row_sel = 3'd0;
  logic [7:0]  row_data;
  logic        reg_wr_valid;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        frame_err;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown;
  logic        display_test;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic       e;
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];

  max7219_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .DIN(DIN), .CS(CS), .SCLK(SCLK),
    .row_sel(row_sel), .row_data(row_data),
    .reg_wr_valid(reg_wr_valid), .reg_addr(reg_addr), .reg_data(reg_data),
    .frame_err(frame_err), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown(shutdown), .display_test(display_test),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic v, input logic e, input logic [3:0] a, input logic [7:0] d);
    exp_t x;
    x.v = v; x.e = e; x.a = a; x.d = d;
    exp_q.push_back(x);
  endtask

  task automatic cs_low();
    @(negedge clk); CS = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DIN = val[i];
      repeat (2) @(negedge clk);
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [31:0] val, input int n);
    cs_low();
    send_bits(val, n);
    cs_high();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_row_data"}, row_data, 8'h00);
    chk({tag, "_wr_valid"}, reg_wr_valid, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_reg_addr"}, reg_addr, 4'h0);
    chk({tag, "_reg_data"}, reg_data, 8'h00);
    chk({tag, "_decode_mode"}, decode_mode, 8'h00);
    chk({tag, "_intensity"}, intensity, 4'h0);
    chk({tag, "_scan_limit"}, scan_limit, 3'd0);
    chk({tag, "_shutdown"}, shutdown, 1'b1);
    chk({tag, "_display_test"}, display_test, 1'b0);
    chk({tag, "_frame_count"}, frame_count, 16'd0);
  endtask

  // Monitor: every cycle with a pulse consumes one expected event
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (reg_wr_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event valid=%0b err=%0b addr=0x%0h data=0x%0h",
                   reg_wr_valid, frame_err, reg_addr, reg_data);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("ev_valid", reg_wr_valid, x.v);
          chk("ev_err", frame_err, x.e);
          chk("ev_addr", reg_addr, x.a);
          chk("ev_data", reg_data, x.d);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    push(1, 0, 4'hC, 8'h01);
    frame(32'h0C01, 16);
    chk("single_shutdown", shutdown, 1'b0);
    chk("single_count", frame_count, 16'd1);

    push(1, 0, 4'h3, 8'h81);
    frame(32'h0381, 16);
    push(1, 0, 4'h8, 8'hFF);
    frame(32'h08FF, 16);
    chk("digit_count", frame_count, 16'd3);
    row_sel = 3'd2; @(negedge clk);
    chk("row2", row_data, 8'h81);
    row_sel = 3'd7; @(negedge clk);
    chk("row7", row_data, 8'hFF);
    row_sel = 3'd0; @(negedge clk);
    chk("row0", row_data, 8'h00);
    row_sel = 3'd5; @(negedge clk);
    chk("row5", row_data, 8'h00);

    push(0, 1, 4'h8, 8'hFF);
    frame(32'hA55, 12);
    chk("short_count", frame_count, 16'd3);
    chk("short_intensity", intensity, 4'h0);

    push(1, 1, 4'hA, 8'h07);
    frame(32'hAA0A07, 24);
    chk("long_intensity", intensity, 4'h7);
    chk("long_count", frame_count, 16'd4);

    push(1, 0, 4'hB, 8'hFD);
    frame(32'h0BFD, 16);
    chk("scan_limit", scan_limit, 3'd5);
    push(1, 0, 4'h9, 8'h3C);
    frame(32'h093C, 16);
    chk("decode_mode", decode_mode, 8'h3C);
    push(1, 0, 4'hD, 8'h55);
    frame(32'h0D55, 16);
    chk("ignored_count", frame_count, 16'd7);

    cs_low();
    send_bits(32'h0F, 8);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    @(negedge clk); rst_n = 1'b1;
    send_bits(32'h01, 8);
    push(0, 1, 4'h0, 8'h00);
    cs_high();
    chk("midrst_count", frame_count, 16'd0);
    chk("midrst_dtest", display_test, 1'b0);

    push(1, 0, 4'hF, 8'h01);
    frame(32'h0F01, 16);
    chk("dtest_on", display_test, 1'b1);
    chk("dtest_count", frame_count, 16'd1);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
